key_input_multi: RTL
====================

// Module: key_input_multi
// PURPOSE
// Parametrised N-channel pushbutton front end replacing single-key debounce at the board top level.
// Per channel: synchronises raw key, debounces, emits one-cycle press/release pulses, long-press flag
// and optional auto-repeat press pulses (held key steps num_clk-style inputs to control).
// Channels fully independent; one instance serves all board keys.
// PARAMETERS
// NUM_KEYS       4         number of independent key channels (>=1)
// ACTIVE_LOW     1         1: key_raw low = pressed (board KEYs); 0: high = pressed
// STABLE_CYCLES  1000000   consecutive disagreeing cycles before debounced level flips (>=1; 20 ms @ 50 MHz)
// REPEAT_DELAY   25000000  cycles from press pulse to long-press / first repeat (>=1)
// REPEAT_RATE    5000000   cycles between subsequent repeat pulses (>=1)
// PORTS
// clk          in   1         system clock (CLOCK_50), all logic on rising edge
// rst_n        in   1         asynchronous active-low reset
// key_raw      in   NUM_KEYS  raw asynchronous key inputs, polarity per ACTIVE_LOW
// repeat_en    in   NUM_KEYS  per-channel auto-repeat enable, sampled each cycle
// key_level    out  NUM_KEYS  debounced level, 1 = pressed
// key_press    out  NUM_KEYS  1-cycle pulse: debounced press, and each auto-repeat
// key_release  out  NUM_KEYS  1-cycle pulse: debounced release
// key_long     out  NUM_KEYS  level: held >= REPEAT_DELAY cycles since press pulse
// BEHAVIOUR
// Reset: rst_n asserts asynchronously; all outputs 0, synchronisers/counters 0, all channels IDLE.
//   Key held through reset deassertion is treated as a new press (pulse after debounce).
// Input: 2-FF synchroniser per channel, then polarity normalised to p = pressed.
// Debounce (per channel, counter width $clog2(STABLE_CYCLES+1)):
//   p != key_level: cnt==STABLE_CYCLES-1 -> key_level<=p, cnt<=0; else cnt<=cnt+1.
//   p == key_level: cnt<=0 (any bounce restarts the count).
//   Latency raw edge -> key_level: 2 sync cycles + STABLE_CYCLES cycles.
// key_press/key_release are registered; asserted exactly in the first cycle key_level shows new value.
// Hold FSM per channel, states IDLE, HELD, REPEAT; hold counter hcnt sized for max(REPEAT_DELAY,REPEAT_RATE):
//   IDLE  : debounced press -> key_press pulse, hcnt<=0, -> HELD.
//   HELD  : hcnt counts up each cycle; at REPEAT_DELAY cycles after press pulse (cycle P+REPEAT_DELAY):
//           key_long<=1, key_press pulse iff repeat_en, hcnt<=0, -> REPEAT.
//   REPEAT: key_long stays 1; pulse at every REPEAT_RATE cycles (P+REPEAT_DELAY+k*REPEAT_RATE) iff repeat_en.
//   HELD/REPEAT + debounced release -> key_release pulse, key_long<=0, hcnt<=0, -> IDLE.
// Simultaneous release and scheduled repeat/long event in same cycle: release wins, no press pulse,
//   key_long not set. key_press and key_release never both high on one channel.
// repeat_en low suppresses repeat pulses only; schedule keeps running, rising repeat_en resumes on grid.
// No counter wraps: debounce and hold counters clear on every terminal event.
// Reset mid-hold: outputs drop immediately; no release pulse generated.
// TESTING (bench params: NUM_KEYS=2, ACTIVE_LOW=1, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
// 1 key_raw[0] 1->0 held -> key_level[0]=1 and key_press[0] 1-cycle pulse exactly 6 cycles after edge; ch1 idle.
// 2 key_raw[0] bounce 0,0,0,1,0... -> no key_level change until 4 consecutive low sync samples; single press pulse.
// 3 hold ch0, repeat_en=1, 25 cycles -> press pulses at P, P+10, P+13, P+16, P+19, P+22; key_long=1 from P+10.
// 4 same hold with repeat_en=0 -> only press at P; key_long=1 at P+10; release -> key_release pulse, key_long=0.
// 5 both channels pressed same cycle, released at different times -> independent pulses, no cross-talk.
// 6 rst_n low mid-REPEAT -> all outputs 0 same cycle; key still held at rst_n rise -> press pulse 6 cycles later.

Source files
------------

// File: rtl/key_input_multi.sv
// key_input_multi: N-channel pushbutton front end.
// Each channel synchronises its raw key, debounces it, and emits one-cycle
// press/release pulses, a long-press level and optional auto-repeat pulses.
// Channels share nothing but the clock and reset.
module key_input_multi #(
    parameter int NUM_KEYS      = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW       = $clog2(STABLE_CYCLES + 1);
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LAST   = HW'(REPEAT_RATE - 1);

    // Folding polarity into the sampled value keeps the reset value of the
    // synchroniser (0) equal to "not pressed" for either key polarity.
    localparam logic INVERT = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } hold_state_t;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic            sync_p0;
        logic            sync_p1;
        logic [CW-1:0]   cnt;
        logic            level;
        logic            flip;
        logic            press_evt;
        logic            release_evt;

        hold_state_t     state;
        hold_state_t     state_nxt;
        logic [HW-1:0]   hcnt;
        logic [HW-1:0]   hcnt_nxt;
        logic            press_r;
        logic            press_nxt;
        logic            release_r;
        logic            release_nxt;
        logic            long_r;
        logic            long_nxt;

        // Two-flop synchroniser on the polarity-normalised key (1 = pressed).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= key_raw[k] ^ INVERT;
                sync_p1 <= sync_p0;
            end
        end

        // The debounced level flips on the cycle the disagreement reaches
        // STABLE_CYCLES consecutive samples; the FSM sees that as an event.
        assign flip        = (sync_p1 != level) && (cnt == STABLE_LAST);
        assign press_evt   = flip &  sync_p1;
        assign release_evt = flip & ~sync_p1;

        // Debounce counter: any sample agreeing with the level restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync_p1 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        // Hold FSM state and registered pulse/level outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                hcnt      <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                state     <= state_nxt;
                hcnt      <= hcnt_nxt;
                press_r   <= press_nxt;
                release_r <= release_nxt;
                long_r    <= long_nxt;
            end
        end

        // Hold FSM next state: release always beats a scheduled long/repeat event.
        always_comb begin
            state_nxt   = state;
            hcnt_nxt    = hcnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = long_r;
            case (state)
                IDLE: begin
                    if (press_evt) begin
                        press_nxt = 1'b1;
                        hcnt_nxt  = '0;
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    if (release_evt) begin
                        release_nxt = 1'b1;
                        long_nxt    = 1'b0;
                        hcnt_nxt    = '0;
                        state_nxt   = IDLE;
                    end else if (hcnt == DELAY_LAST) begin
                        long_nxt  = 1'b1;
                        press_nxt = repeat_en[k];
                        hcnt_nxt  = '0;
                        state_nxt = REPEAT;
                    end else begin
                        hcnt_nxt = hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (release_evt) begin
                        release_nxt = 1'b1;
                        long_nxt    = 1'b0;
                        hcnt_nxt    = '0;
                        state_nxt   = IDLE;
                    end else if (hcnt == RATE_LAST) begin
                        // Schedule runs regardless of repeat_en so re-enabling stays on grid.
                        press_nxt = repeat_en[k];
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hcnt_nxt  = '0;
                    long_nxt  = 1'b0;
                end
            endcase
        end

        assign key_level[k]   = level;
        assign key_press[k]   = press_r;
        assign key_release[k] = release_r;
        assign key_long[k]    = long_r;
    end

endmodule
